// File: rtl/booth_multiplier_16.sv
`default_nettype none
// ============================================================================
//  Module      : booth_multiplier_16 (with complement_16, carry_select_adder_16)
//  Description : Sequential 16x16 signed radix-2 Booth multiplier. One Booth
//                step per cycle; product valid 16 cycles after start.
//                Optional macro MUL_OF_EN enables the 16-bit overflow flag OF;
//                when undefined, OF is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  complement_16 : 16-bit two's-complement negation
// ----------------------------------------------------------------------------
module complement_16 (
    input  logic [15:0] i_a,
    output logic [15:0] o_neg
);
    assign o_neg = ~i_a + 16'd1;
endmodule

// ----------------------------------------------------------------------------
//  carry_select_adder_16 : four 4-bit blocks, each precomputing both carry-in
//  cases and selecting with the ripple of block carries.
// ----------------------------------------------------------------------------
module carry_select_adder_16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    output logic [15:0] o_sum,
    output logic        o_cout
);
    localparam int c_BLK = 4;

    logic [c_BLK:0] w_c;

    assign w_c[0] = i_cin;

    generate
        for (genvar k = 0; k < c_BLK; k++) begin : g_blk
            logic [4:0] w_s0;
            logic [4:0] w_s1;
            assign w_s0 = {1'b0, i_a[4*k +: 4]} + {1'b0, i_b[4*k +: 4]};
            assign w_s1 = {1'b0, i_a[4*k +: 4]} + {1'b0, i_b[4*k +: 4]} + 5'd1;
            assign o_sum[4*k +: 4] = w_c[k] ? w_s1[3:0] : w_s0[3:0];
            assign w_c[k+1]        = w_c[k] ? w_s1[4]   : w_s0[4];
        end
    endgenerate

    assign o_cout = w_c[c_BLK];
endmodule

// ----------------------------------------------------------------------------
//  booth_multiplier_16 : top level
// ----------------------------------------------------------------------------
module booth_multiplier_16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic        busy,
    output logic        done,
    output logic [31:0] p,
    output logic        OF
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [16:0] r_m;
    logic [16:0] r_nm;
    logic [16:0] r_a;
    logic [15:0] r_q;
    logic        r_q1;
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_p;

    logic [15:0] w_neg_x;
    logic [16:0] w_addend;
    logic [15:0] w_sum_lo;
    logic        w_c16;
    logic [16:0] w_sum;
    logic [16:0] w_a_sh;
    logic [15:0] w_q_sh;
    logic [31:0] w_prod;

    // Low 16 bits of -x; bit 16 is fixed up at latch time so -(-32768) = +32768
    complement_16 u_cmp (
        .i_a   (x),
        .o_neg (w_neg_x)
    );

    // Booth recoding of {Q[0], q_1}: 01 adds M, 10 adds -M, else adds zero
    always_comb begin
        w_addend = 17'd0;
        case ({r_q[0], r_q1})
            2'b01:   w_addend = r_m;
            2'b10:   w_addend = r_nm;
            default: w_addend = 17'd0;
        endcase
    end

    carry_select_adder_16 u_add (
        .i_a    (r_a[15:0]),
        .i_b    (w_addend[15:0]),
        .i_cin  (1'b0),
        .o_sum  (w_sum_lo),
        .o_cout (w_c16)
    );

    // Bit 16 of the 17-bit sum; the final carry-out is discarded
    assign w_sum  = {r_a[16] ^ w_addend[16] ^ w_c16, w_sum_lo};

    // Arithmetic right shift of {A, Q, q_1}
    assign w_a_sh = {w_sum[16], w_sum[16:1]};
    assign w_q_sh = {w_sum[0], r_q[15:1]};
    assign w_prod = {w_a_sh[15:0], w_q_sh};

`ifdef MUL_OF_EN
    logic r_of;
    logic w_of_next;
    // Overflow when the upper 17 bits are not a pure sign extension
    assign w_of_next = ~((&w_prod[31:15]) | ~(|w_prod[31:15]));
    assign OF        = r_of;
`else
    assign OF        = 1'b0;
`endif

    // Control FSM and datapath registers; reset wins over start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_m     <= 17'd0;
            r_nm    <= 17'd0;
            r_a     <= 17'd0;
            r_q     <= 16'd0;
            r_q1    <= 1'b0;
            r_cnt   <= 5'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_p     <= 32'd0;
`ifdef MUL_OF_EN
            r_of    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_m     <= {x[15], x};
                        r_nm    <= {~x[15] & (|x), w_neg_x};
                        r_a     <= 17'd0;
                        r_q     <= y;
                        r_q1    <= 1'b0;
                        r_cnt   <= 5'd16;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_a   <= w_a_sh;
                    r_q   <= w_q_sh;
                    r_q1  <= r_q[0];
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_p     <= w_prod;
`ifdef MUL_OF_EN
                        r_of    <= w_of_next;
`endif
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign p    = r_p;

endmodule
`default_nettype wire

// File: tb/tb_booth_multiplier_16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_multiplier_16
//  Description : Scoreboard bench for booth_multiplier_16. Driver pushes the
//                expected product for each accepted start; a monitor pops and
//                compares on every done pulse and checks the busy length.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_multiplier_16;

    typedef struct packed {
        logic [31:0] p;
        logic        of;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] x;
    logic [15:0] y;
    logic        busy;
    logic        done;
    logic [31:0] p;
    logic        OF;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   busy_cnt = 0;
    int   done_seen = 0;

    booth_multiplier_16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .p     (p),
        .OF    (OF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic of_ref(input logic [31:0] prod);
`ifdef MUL_OF_EN
        return ($signed(prod) > 32'sd32767) || ($signed(prod) < -32'sd32768);
`else
        return 1'b0;
`endif
    endfunction

    // Monitor: compare every done pulse against the scoreboard head
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                done_seen++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("product", p, e.p);
                    check("overflow", {31'd0, OF}, {31'd0, e.of});
                    check("latency", busy_cnt, 16);
                end
                busy_cnt = 0;
            end
        end
    end

    // Wait for the DUT to be idle (bounded)
    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || done) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) check("idle_timeout", 32'd1, 32'd0);
    endtask

    // Issue one multiply; hold start one cycle
    task automatic issue(input logic [15:0] xa, input logic [15:0] ya, input logic push, input logic [31:0] ep, input logic eof);
        exp_t e;
        wait_idle();
        x = xa; y = ya; start = 1'b1;
        if (push) begin
            e.p  = ep;
            e.of = eof;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
        x = $urandom; y = $urandom;
    endtask

    // Wait until the scoreboard drains (bounded)
    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) begin
            check("done_timeout", sb.size(), 0);
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic mul(input logic [15:0] xa, input logic [15:0] ya, input logic [31:0] ep, input logic eof_en);
`ifdef MUL_OF_EN
        issue(xa, ya, 1'b1, ep, eof_en);
`else
        issue(xa, ya, 1'b1, ep, 1'b0 & eof_en);
`endif
        drain();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [15:0] rx;
        logic [15:0] ry;
        logic [31:0] rp;
        int          seen0;

        rst_n = 1'b0; start = 1'b0; x = 16'd0; y = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_p", p, 32'd0);
        check("rst_of", {31'd0, OF}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors: x, y, product, overflow (when enabled)
        mul(16'h0003, 16'h0005, 32'h0000000F, 1'b0);
        mul(16'hFFF9, 16'h0006, 32'hFFFFFFD6, 1'b0);
        mul(16'h8000, 16'h8000, 32'h40000000, 1'b1);
        mul(16'h0000, 16'h8000, 32'h00000000, 1'b0);
        mul(16'h7FFF, 16'h7FFF, 32'h3FFF0001, 1'b1);
        mul(16'hFFFF, 16'hFFFF, 32'h00000001, 1'b0);
        mul(16'h7FFF, 16'hFFFF, 32'hFFFF8001, 1'b0);
        mul(16'h8000, 16'h0001, 32'hFFFF8000, 1'b0);
        mul(16'h8000, 16'hFFFF, 32'h00008000, 1'b1);
        mul(16'h0100, 16'h0100, 32'h00010000, 1'b1);
        mul(16'hFF00, 16'h0100, 32'hFFFF0000, 1'b1);
        mul(16'h1234, 16'h0010, 32'h00012340, 1'b1);

        // Start during CALC is ignored
        issue(16'h0003, 16'h0005, 1'b1, 32'h0000000F, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        x = 16'h0064; y = 16'h0064; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drain();
        check("ignored_start_p", p, 32'h0000000F);

        // Reset mid-CALC discards the operation
        issue(16'h0007, 16'h0009, 1'b0, 32'd0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_p", p, 32'd0);
        seen0 = done_seen;
        repeat (25) @(posedge clk);
        #1;
        check("midrst_no_done", done_seen - seen0, 0);

        // Random signed pairs against the native signed product
        for (int i = 0; i < 1000; i++) begin
            rx = $urandom;
            ry = $urandom;
            rp = $signed(rx) * $signed(ry);
            issue(rx, ry, 1'b1, rp, of_ref(rp));
            drain();
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
